// File: rtl/aq_mem_arbiter_if.sv
// Bus bundle between the arbiter (slave side) and its requesters plus the RAM (master side).
// Handshakes: cpu_ce is a one-cycle command strobe with no back-pressure except cpu_stall; dl_wr is a
// fire-and-forget pulse (dl_busy/dl_ovf report buffer state); tp_req is a level held until the
// one-cycle tp_ack, which carries tp_data in the same cycle; mem_q is valid the cycle after mem_addr.
interface aq_mem_arbiter_if #(
    parameter int AW = 16
);
    logic          cpu_ce;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_din;
    logic          cpu_we;
    logic [7:0]    cpu_q;
    logic          cpu_stall;

    logic          dl_wr;
    logic [AW-1:0] dl_addr;
    logic [7:0]    dl_data;
    logic          dl_busy;
    logic          dl_ovf;

    logic          tp_req;
    logic [AW-1:0] tp_addr;
    logic          tp_ack;
    logic [7:0]    tp_data;

    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_d;
    logic          mem_we;
    logic [7:0]    mem_q;

    modport slave (
        input  cpu_ce, cpu_addr, cpu_din, cpu_we,
        output cpu_q, cpu_stall,
        input  dl_wr, dl_addr, dl_data,
        output dl_busy, dl_ovf,
        input  tp_req, tp_addr,
        output tp_ack, tp_data,
        output mem_addr, mem_d, mem_we,
        input  mem_q
    );

    modport master (
        output cpu_ce, cpu_addr, cpu_din, cpu_we,
        input  cpu_q, cpu_stall,
        output dl_wr, dl_addr, dl_data,
        input  dl_busy, dl_ovf,
        output tp_req, tp_addr,
        input  tp_ack, tp_data,
        input  mem_addr, mem_d, mem_we,
        output mem_q
    );
endinterface

// File: rtl/aq_mem_arbiter.sv
// Single-port RAM arbiter: CPU on its clock-enable, download writer and tape reader round-robin in idle
// cycles, with a starvation stall. Optional grant/stall statistics when ARB_STATS_EN is defined.
module aq_mem_arbiter #(
    parameter int AW         = 16,
    parameter int DL_BASE    = 'hC000,
    parameter int STARVE_MAX = 8
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    aq_mem_arbiter_if.slave      bus,
    output logic [1:0]           dbg_grant
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]          stat_dl,
    output logic [15:0]          stat_tp,
    output logic [15:0]          stat_stall
`endif
);

    localparam logic [AW-1:0] DL_OFS     = AW'(DL_BASE);
    localparam logic [7:0]    STARVE_LIM = 8'(STARVE_MAX);

    typedef enum logic [1:0] {
        G_IDLE = 2'd0,
        G_CPU  = 2'd1,
        G_DL   = 2'd2,
        G_TP   = 2'd3
    } grant_t;

    grant_t        grant, grant_q;
    logic          rr_tp, rr_tp_next;
    logic [7:0]    starve_cnt, starve_next;
    logic          stall, dl_pend, tp_pend;

    logic          dl_busy_q, dl_ovf_q;
    logic [AW-1:0] dl_buf_addr;
    logic [7:0]    dl_buf_data;

    logic [AW-1:0] mem_addr_q;
    logic [7:0]    mem_d_q;
    logic          mem_we_q;

    logic          cpu_rd_s1, cpu_rd_s2, tp_s1, tp_s2;
    logic [7:0]    cpu_q_hold;

    // Grant, round-robin pointer and starvation counter for the current cycle.
    always_comb begin
        dl_pend     = dl_busy_q;
        tp_pend     = bus.tp_req & ~tp_s1 & ~tp_s2;
        stall       = (starve_cnt == STARVE_LIM);
        grant       = G_IDLE;
        rr_tp_next  = rr_tp;
        starve_next = starve_cnt;

        if (bus.cpu_ce)
            grant = G_CPU;
        else if (dl_pend && tp_pend)
            grant = rr_tp ? G_TP : G_DL;
        else if (dl_pend)
            grant = G_DL;
        else if (tp_pend)
            grant = G_TP;

        if (grant == G_DL)
            rr_tp_next = 1'b1;
        else if (grant == G_TP)
            rr_tp_next = 1'b0;

        if (stall || grant == G_DL || grant == G_TP || !(dl_pend || tp_pend))
            starve_next = 8'd0;
        else if (bus.cpu_ce && starve_cnt < STARVE_LIM)
            starve_next = starve_cnt + 8'd1;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            grant_q    <= G_IDLE;
            rr_tp      <= 1'b0;
            starve_cnt <= 8'd0;
        end else begin
            grant_q    <= grant;
            rr_tp      <= rr_tp_next;
            starve_cnt <= starve_next;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            mem_addr_q  <= '0;
            mem_d_q     <= 8'd0;
            mem_we_q    <= 1'b0;
            dl_busy_q   <= 1'b0;
            dl_ovf_q    <= 1'b0;
            dl_buf_addr <= '0;
            dl_buf_data <= 8'd0;
            cpu_rd_s1   <= 1'b0;
            cpu_rd_s2   <= 1'b0;
            tp_s1       <= 1'b0;
            tp_s2       <= 1'b0;
            cpu_q_hold  <= 8'd0;
        end else begin
            mem_we_q <= 1'b0;
            case (grant)
                G_CPU: begin
                    mem_addr_q <= bus.cpu_addr;
                    mem_d_q    <= bus.cpu_din;
                    mem_we_q   <= bus.cpu_we;
                end
                G_DL: begin
                    mem_addr_q <= dl_buf_addr;
                    mem_d_q    <= dl_buf_data;
                    mem_we_q   <= 1'b1;
                end
                G_TP: mem_addr_q <= bus.tp_addr;
                default: ;
            endcase

            cpu_rd_s1 <= (grant == G_CPU) && !bus.cpu_we;
            cpu_rd_s2 <= cpu_rd_s1;
            tp_s1     <= (grant == G_TP);
            tp_s2     <= tp_s1;
            if (cpu_rd_s2)
                cpu_q_hold <= bus.mem_q;

            // A write arriving while the old entry is being granted simply refills the buffer.
            if (bus.dl_wr) begin
                if (!dl_busy_q || grant == G_DL) begin
                    dl_buf_addr <= bus.dl_addr + DL_OFS;
                    dl_buf_data <= bus.dl_data;
                    dl_busy_q   <= 1'b1;
                end else begin
                    dl_ovf_q <= 1'b1;
                end
            end else if (grant == G_DL) begin
                dl_busy_q <= 1'b0;
            end
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            stat_dl    <= 16'd0;
            stat_tp    <= 16'd0;
            stat_stall <= 16'd0;
        end else begin
            if (grant == G_DL && stat_dl != 16'hFFFF)
                stat_dl <= stat_dl + 16'd1;
            if (grant == G_TP && stat_tp != 16'hFFFF)
                stat_tp <= stat_tp + 16'd1;
            if (stall && stat_stall != 16'hFFFF)
                stat_stall <= stat_stall + 16'd1;
        end
    end
`endif

    // Read data is forwarded straight from the RAM in its return cycle so a CPU ce two cycles later sees it.
    assign bus.cpu_q     = cpu_rd_s2 ? bus.mem_q : cpu_q_hold;
    assign bus.cpu_stall = stall;
    assign bus.dl_busy   = dl_busy_q;
    assign bus.dl_ovf    = dl_ovf_q;
    assign bus.tp_ack    = tp_s2;
    assign bus.tp_data   = tp_s2 ? bus.mem_q : 8'd0;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_d     = mem_d_q;
    assign bus.mem_we    = mem_we_q;
    assign dbg_grant     = grant_q;

endmodule

// File: tb/tb_aq_mem_arbiter.sv
// Bench for aq_mem_arbiter: directed scenarios followed by randomized CPU/download/tape traffic
// checked against a memory-level reference model.
module tb_aq_mem_arbiter;
  localparam int AW = 16;
  localparam int STARVE_MAX = 8;

  logic clk_sys = 1'b0;
  logic reset;
  logic ce_raw;
  logic preload;
  logic [1:0] dbg_grant;
`ifdef ARB_STATS_EN
  logic [15:0] stat_dl, stat_tp, stat_stall;
`endif

  always #5 clk_sys = ~clk_sys;

  aq_mem_arbiter_if #(.AW(AW)) bus ();

  assign bus.cpu_ce = ce_raw & ~bus.cpu_stall;

  aq_mem_arbiter #(.AW(AW), .DL_BASE('hC000), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .bus       (bus),
    .dbg_grant (dbg_grant)
`ifdef ARB_STATS_EN
    ,
    .stat_dl   (stat_dl),
    .stat_tp   (stat_tp),
    .stat_stall(stat_stall)
`endif
  );

  // RAM model: 1-cycle registered read, read-before-write.
  logic [7:0] ram [0:65535];

  function automatic logic [7:0] init_val(input int a);
    if (a == 'h0100) return 8'h3C;
    if (a >= 'h4000 && a <= 'h40FF) return 8'(a) ^ 8'h5C;
    return 8'h00;
  endfunction

  always @(posedge clk_sys) begin
    if (preload) begin
      for (int i = 0; i < 65536; i++) ram[i] <= init_val(i);
    end else if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_d;
    end
    bus.mem_q <= ram[bus.mem_addr];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic idle_inputs();
    ce_raw = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_din = 8'h00;
    bus.dl_wr = 1'b0; bus.dl_addr = '0; bus.dl_data = 8'h00;
    bus.tp_req = 1'b0; bus.tp_addr = '0;
  endtask

  // scoreboard for CPU reads: expected byte and the cycle it must appear on cpu_q
  logic [7:0] exp_q[$];
  int due_q[$];
  logic [7:0] shadow [0:63];
  logic [7:0] dl_model [0:255];
  bit dl_written [0:255];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_ce, found, stall_seen, gap, need, dl_gap, tp_wait, cyc;
    bit tp_active;
    logic [7:0] tp_exp, got_d;
    logic [15:0] got_a;

    // ---- reset with all inputs active ----
    reset = 1'b1; preload = 1'b1;
    ce_raw = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h1234; bus.cpu_din = 8'hFF;
    bus.dl_wr = 1'b1; bus.dl_addr = 16'h0005; bus.dl_data = 8'h77;
    bus.tp_req = 1'b1; bus.tp_addr = 16'h4000;
    step(); preload = 1'b0;
    step(); step();
    @(negedge clk_sys);
    check_eq("rst_cpu_q", bus.cpu_q, 0);
    check_eq("rst_stall", bus.cpu_stall, 0);
    check_eq("rst_dl_busy", bus.dl_busy, 0);
    check_eq("rst_dl_ovf", bus.dl_ovf, 0);
    check_eq("rst_tp_ack", bus.tp_ack, 0);
    check_eq("rst_tp_data", bus.tp_data, 0);
    check_eq("rst_mem_we", bus.mem_we, 0);
    check_eq("rst_mem_addr", bus.mem_addr, 0);
    check_eq("rst_mem_d", bus.mem_d, 0);
    check_eq("rst_grant", dbg_grant, 0);
    step(); reset = 1'b0; idle_inputs();
    @(negedge clk_sys);
    check_eq("post_rst_we1", bus.mem_we, 0);
    step();
    @(negedge clk_sys);
    check_eq("post_rst_we2", bus.mem_we, 0);
    check_eq("post_rst_busy", bus.dl_busy, 0);

    // ---- CPU write then read, ce every 4 cycles ----
    stall_seen = 0;
    step(); ce_raw = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h3900; bus.cpu_din = 8'h5A;
    @(negedge clk_sys); stall_seen += int'(bus.cpu_stall);
    step(); ce_raw = 1'b0; bus.cpu_we = 1'b0;
    @(negedge clk_sys); stall_seen += int'(bus.cpu_stall);
    check_eq("cpu_wr_we", bus.mem_we, 1);
    check_eq("cpu_wr_addr", bus.mem_addr, 16'h3900);
    check_eq("cpu_wr_d", bus.mem_d, 8'h5A);
    step(); @(negedge clk_sys); stall_seen += int'(bus.cpu_stall);
    step(); @(negedge clk_sys); stall_seen += int'(bus.cpu_stall);
    step(); ce_raw = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h3900;
    @(negedge clk_sys); stall_seen += int'(bus.cpu_stall);
    step(); ce_raw = 1'b0;
    @(negedge clk_sys); stall_seen += int'(bus.cpu_stall);
    check_eq("cpu_rd_we", bus.mem_we, 0);
    step(); @(negedge clk_sys); stall_seen += int'(bus.cpu_stall);
    check_eq("cpu_rd_q", bus.cpu_q, 8'h5A);
    step(); @(negedge clk_sys); stall_seen += int'(bus.cpu_stall);
    check_eq("cpu_rd_hold", bus.cpu_q, 8'h5A);
    check_eq("cpu_no_stall", stall_seen, 0);

    // ---- single download byte with CPU idle ----
    step(); bus.dl_wr = 1'b1; bus.dl_addr = 16'h0010; bus.dl_data = 8'hA5;
    @(negedge clk_sys);
    step(); bus.dl_wr = 1'b0;
    @(negedge clk_sys);
    check_eq("dl_busy_set", bus.dl_busy, 1);
    step(); @(negedge clk_sys);
    check_eq("dl_busy_clr", bus.dl_busy, 0);
    check_eq("dl_we", bus.mem_we, 1);
    check_eq("dl_addr", bus.mem_addr, 16'hC010);
    check_eq("dl_d", bus.mem_d, 8'hA5);
    step(); @(negedge clk_sys);
    check_eq("dl_we_once", bus.mem_we, 0);

    // ---- overflow while CPU holds the RAM ----
    step(); ce_raw = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0200;
    bus.dl_wr = 1'b1; bus.dl_addr = 16'h0020; bus.dl_data = 8'h11;
    @(negedge clk_sys);
    step(); bus.dl_addr = 16'h0021; bus.dl_data = 8'h22;
    @(negedge clk_sys);
    check_eq("ovf_busy", bus.dl_busy, 1);
    check_eq("ovf_not_yet", bus.dl_ovf, 0);
    step(); bus.dl_wr = 1'b0;
    @(negedge clk_sys);
    check_eq("ovf_set", bus.dl_ovf, 1);
    found = 0; got_a = '0; got_d = '0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      step(); @(negedge clk_sys);
      if (bus.mem_we) begin found = 1; got_a = bus.mem_addr; got_d = bus.mem_d; end
    end
    check_eq("ovf_first_written", found, 1);
    check_eq("ovf_first_addr", got_a, 16'hC020);
    check_eq("ovf_first_d", got_d, 8'h11);
    step(); ce_raw = 1'b0;
    step(); step(); @(negedge clk_sys);
    check_eq("ovf_dropped", ram[16'hC021], 8'h00);
    check_eq("ovf_sticky", bus.dl_ovf, 1);

    // ---- starvation guard with tape pending ----
    step(); ce_raw = 1'b1; bus.tp_req = 1'b1; bus.tp_addr = 16'h0100;
    n_ce = 0; found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk_sys);
      if (bus.cpu_stall) found = 1;
      else begin
        if (bus.cpu_ce) n_ce++;
        step();
      end
    end
    check_eq("starve_stall_seen", found, 1);
    check_eq("starve_ce_count", n_ce, STARVE_MAX);
    step(); @(negedge clk_sys);
    check_eq("starve_stall_1cyc", bus.cpu_stall, 0);
    check_eq("tp_ack_early", bus.tp_ack, 0);
    step(); @(negedge clk_sys);
    check_eq("tp_ack", bus.tp_ack, 1);
    check_eq("tp_data", bus.tp_data, 8'h3C);
    step(); bus.tp_req = 1'b0; @(negedge clk_sys);
    check_eq("tp_ack_pulse", bus.tp_ack, 0);
    check_eq("ovf_still_sticky", bus.dl_ovf, 1);
    step(); ce_raw = 1'b0;

    // ---- DL and TP together with CPU idle: alternating grants ----
    reset = 1'b1; step(); step(); reset = 1'b0;
    @(negedge clk_sys);
    check_eq("ovf_cleared", bus.dl_ovf, 0);
    step(); bus.dl_wr = 1'b1; bus.dl_addr = 16'h0030; bus.dl_data = 8'h61;
    step(); bus.dl_addr = 16'h0031; bus.dl_data = 8'h62; bus.tp_req = 1'b1; bus.tp_addr = 16'h4005;
    step(); bus.dl_wr = 1'b0;
    @(negedge clk_sys);
    check_eq("rr1_dl_we", bus.mem_we, 1);
    check_eq("rr1_dl_addr", bus.mem_addr, 16'hC030);
    step(); bus.dl_wr = 1'b1; bus.dl_addr = 16'h0032; bus.dl_data = 8'h63;
    @(negedge clk_sys);
    check_eq("rr2_tp_we", bus.mem_we, 0);
    check_eq("rr2_tp_addr", bus.mem_addr, 16'h4005);
    step(); bus.dl_wr = 1'b0;
    @(negedge clk_sys);
    check_eq("rr3_dl_we", bus.mem_we, 1);
    check_eq("rr3_dl_addr", bus.mem_addr, 16'hC031);
    check_eq("rr3_dl_d", bus.mem_d, 8'h62);
    check_eq("rr_tp_ack", bus.tp_ack, 1);
    check_eq("rr_tp_data", bus.tp_data, 8'h05 ^ 8'h5C);
    step(); bus.tp_req = 1'b0;
    @(negedge clk_sys);
    check_eq("rr4_dl_addr", bus.mem_addr, 16'hC032);
    check_eq("rr4_dl_d", bus.mem_d, 8'h63);
    check_eq("rr_no_ovf", bus.dl_ovf, 0);
`ifdef ARB_STATS_EN
    check_eq("stat_dl", stat_dl, 3);
    check_eq("stat_tp", stat_tp, 1);
    check_eq("stat_stall", stat_stall, 0);
`endif

    // ---- randomized traffic against the memory model ----
    idle_inputs();
    reset = 1'b1; step(); step(); reset = 1'b0;
    for (int i = 0; i < 64; i++) shadow[i] = 8'h00;
    for (int i = 0; i < 256; i++) begin dl_model[i] = 8'h00; dl_written[i] = 1'b0; end
    gap = 10; need = 2; dl_gap = 20; tp_active = 1'b0; tp_wait = 0; tp_exp = 8'h00;
    for (cyc = 0; cyc < 1500; cyc++) begin
      step();
      if (gap >= need) begin
        ce_raw = 1'b1;
        bus.cpu_we = 1'($urandom_range(0, 1));
        bus.cpu_addr = 16'($urandom_range(0, 63));
        bus.cpu_din = 8'($urandom_range(0, 255));
      end else begin
        ce_raw = 1'b0;
      end
      if (dl_gap >= 12 && $urandom_range(0, 3) == 0) begin
        bus.dl_wr = 1'b1;
        bus.dl_addr = 16'($urandom_range(0, 255));
        bus.dl_data = 8'($urandom_range(0, 255));
        dl_model[bus.dl_addr[7:0]] = bus.dl_data;
        dl_written[bus.dl_addr[7:0]] = 1'b1;
        dl_gap = 0;
      end else begin
        bus.dl_wr = 1'b0;
        dl_gap++;
      end
      if (!tp_active && $urandom_range(0, 2) == 0) begin
        bus.tp_req = 1'b1;
        bus.tp_addr = 16'h4000 | 16'($urandom_range(0, 255));
        tp_exp = bus.tp_addr[7:0] ^ 8'h5C;
        tp_active = 1'b1;
        tp_wait = 0;
      end
      @(negedge clk_sys);
      if (bus.cpu_ce) begin
        if (bus.cpu_we) shadow[bus.cpu_addr[5:0]] = bus.cpu_din;
        else begin
          exp_q.push_back(shadow[bus.cpu_addr[5:0]]);
          due_q.push_back(cyc + 2);
        end
        gap = 1;
        need = $urandom_range(2, 5);
      end else begin
        gap++;
      end
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        check_eq("rnd_cpu_q", bus.cpu_q, exp_q[0]);
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
      if (tp_active) begin
        if (bus.tp_ack) begin
          check_eq("rnd_tp_data", bus.tp_data, tp_exp);
          tp_active = 1'b0;
          bus.tp_req = 1'b0;
        end else begin
          tp_wait++;
          if (tp_wait > 40) begin
            check_eq("rnd_tp_ack_timeout", bus.tp_ack, 1);
            tp_active = 1'b0;
            bus.tp_req = 1'b0;
          end
        end
      end
    end
    idle_inputs();
    repeat (10) step();
    @(negedge clk_sys);
    check_eq("rnd_reads_drained", exp_q.size(), 0);
    check_eq("rnd_no_ovf", bus.dl_ovf, 0);
    for (int i = 0; i < 256; i++) begin
      if (dl_written[i]) check_eq("rnd_dl_mem", ram[16'hC000 + i], dl_model[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
